// File: rtl/line_loader_pkg.sv
// +--------------------------------------------------------------------+
// | loader_pkg: shared constants and FSM encoding for line_loader.     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package loader_pkg;

  localparam int ROW_W  = 5;
  localparam int ROWS   = 5;
  localparam int LINE_W = ROW_W * ROWS;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    LAUNCH  = 2'd2,
    WAIT    = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/line_loader_if.sv
// +--------------------------------------------------------------------+
// | line_loader_if: row stream, line memory and controller signals.    |
// | Parity pins exist only with LINE_LOADER_PARITY_EN. Rev 1.0          |
// +--------------------------------------------------------------------+
`default_nettype none

interface line_loader_if #(
  parameter int ADDR_W = 6
);
  import loader_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ROW_W-1:0]  in_data;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] line_count;
  logic              start;
  logic              proc_done;
  logic              overflow;
  logic              busy;
`ifdef LINE_LOADER_PARITY_EN
  logic              in_par;
  logic              par_err;
`endif

  modport slave (
    input  in_valid, in_data, in_last, proc_done,
`ifdef LINE_LOADER_PARITY_EN
    input  in_par,
    output par_err,
`endif
    output in_ready, mem_we, mem_addr, mem_wdata, line_count, start,
    output overflow, busy
  );

  modport master (
    output in_valid, in_data, in_last, proc_done,
`ifdef LINE_LOADER_PARITY_EN
    output in_par,
    input  par_err,
`endif
    input  in_ready, mem_we, mem_addr, mem_wdata, line_count, start,
    input  overflow, busy
  );

endinterface

`default_nettype wire

// File: rtl/line_loader_packer.sv
// +--------------------------------------------------------------------+
// | line_packer: places accepted rows into a line, row 0 in the LSBs.  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module line_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              accept_i,
  input  logic [ROW_W-1:0]  row_i,
  input  logic              last_i,
  input  logic              clear_i,
  output logic [LINE_W-1:0] line_o,
  output logic [IDX_W-1:0]  row_idx_o,
  output logic              line_done_o
);

  logic [LINE_W-1:0] line_q, line_d;
  logic [IDX_W-1:0]  row_idx_q;

  assign line_done_o = accept_i && ((row_idx_q == IDX_W'(ROWS - 1)) || last_i);
  assign line_o      = line_q;
  assign row_idx_o   = row_idx_q;

  always_comb begin
    line_d = line_q;
    for (int r = 0; r < ROWS; r++) begin
      if (row_idx_q == IDX_W'(r)) line_d[r*ROW_W +: ROW_W] = row_i;
    end
  end

  // Clearing after every write makes unfilled rows of a short line read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q    <= '0;
      row_idx_q <= '0;
    end else if (clear_i) begin
      line_q    <= '0;
      row_idx_q <= '0;
    end else if (accept_i) begin
      line_q <= line_d;
      if (!line_done_o) row_idx_q <= row_idx_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/line_loader.sv
// +--------------------------------------------------------------------+
// | line_loader: packs rows into lines, writes line memory, launches   |
// | the controller. Option: LINE_LOADER_PARITY_EN. Rev 1.0              |
// +--------------------------------------------------------------------+
`default_nettype none

module line_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  line_loader_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic              in_ready_q, mem_we_q, start_q, overflow_q, last_q;
  logic [ADDR_W-1:0] line_count_q;
  logic              accept, line_done;
  logic [LINE_W-1:0] line;
  logic [IDX_W-1:0]  row_idx;

  assign accept = bus.in_valid && in_ready_q;

  line_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .accept_i    (accept),
    .row_i       (bus.in_data),
    .last_i      (bus.in_last),
    .clear_i     (state_q == WRITE),
    .line_o      (line),
    .row_idx_o   (row_idx),
    .line_done_o (line_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= COLLECT;
      in_ready_q   <= 1'b1;
      mem_we_q     <= 1'b0;
      start_q      <= 1'b0;
      overflow_q   <= 1'b0;
      last_q       <= 1'b0;
      line_count_q <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (line_done) begin
            state_q    <= WRITE;
            last_q     <= bus.in_last;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b1;
          end
        end
        WRITE: begin
          mem_we_q     <= 1'b0;
          line_count_q <= line_count_q + 1'b1;
          if (last_q || line_count_q == LAST_LINE) begin
            state_q <= LAUNCH;
            start_q <= 1'b1;
            if (!last_q) overflow_q <= 1'b1;
          end else begin
            state_q    <= COLLECT;
            in_ready_q <= 1'b1;
          end
        end
        LAUNCH: begin
          start_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.proc_done) begin
            state_q      <= COLLECT;
            in_ready_q   <= 1'b1;
            line_count_q <= '0;
            overflow_q   <= 1'b0;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = line_count_q;
  assign bus.mem_wdata  = line;
  assign bus.line_count = line_count_q;
  assign bus.start      = start_q;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = !(state_q == COLLECT && row_idx == '0);

`ifdef LINE_LOADER_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else if (state_q == WAIT && bus.proc_done) begin
      par_err_q <= 1'b0;
    end else if (accept && ^{bus.in_data, bus.in_par}) begin
      par_err_q <= 1'b1;
    end
  end

  assign bus.par_err = par_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_line_loader.sv
// +--------------------------------------------------------------------+
// | tb_line_loader: directed self-checking bench for line_loader.      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_line_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total    = 0;
  int   start_cnt = 0;
  logic [5:0]  wa[$];
  logic [24:0] wd[$];

  line_loader_if #(.ADDR_W(6)) bus ();

  line_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
    if (bus.start) start_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_row_p(input logic [4:0] d, input logic l, input logic p);
    int   n;
    logic rdy;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
`ifdef LINE_LOADER_PARITY_EN
    bus.in_par   = p;
`else
    if (p) n = 0;
`endif
    n = 0;
    forever begin
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 1000) begin
        total++;
        fail_cnt++;
        $error("FAIL send_timeout: observed no accept expected accept");
        break;
      end
      tick();
    end
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_row(input logic [4:0] d, input logic l);
    send_row_p(d, l, ^d);
  endtask

  task automatic wait_start(input string tag, input int base);
    for (int n = 0; n < 20 && start_cnt <= base; n++) tick();
    check(tag, start_cnt - base, 1);
  endtask

  task automatic done_pulse(input string tag);
    bus.proc_done = 1'b1;
    tick();
    bus.proc_done = 1'b0;
    check({tag, "_ready"}, bus.in_ready, 1'b1);
    check({tag, "_count"}, bus.line_count, 6'd0);
  endtask

  initial begin
    int          wbase, sbase, errs;
    logic [24:0] exp_line;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.proc_done = 1'b0;
`ifdef LINE_LOADER_PARITY_EN
    bus.in_par    = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_start", bus.start, 1'b0);
    check("rst_line_count", bus.line_count, 6'd0);
    check("rst_overflow", bus.overflow, 1'b0);
    check("rst_busy", bus.busy, 1'b0);

    // Single full line; proc_done pulsed mid-line must be ignored.
    wbase = wa.size();
    send_row(5'h01, 1'b0);
    send_row(5'h02, 1'b0);
    send_row(5'h03, 1'b0);
    check("t1_busy_mid", bus.busy, 1'b1);
    bus.proc_done = 1'b1;
    tick();
    bus.proc_done = 1'b0;
    check("t1_ready_after_stray_done", bus.in_ready, 1'b1);
    send_row(5'h04, 1'b0);
    send_row(5'h05, 1'b1);
    check("t1_we", bus.mem_we, 1'b1);
    check("t1_addr", bus.mem_addr, 6'd0);
    check("t1_wdata", bus.mem_wdata, {5'h05, 5'h04, 5'h03, 5'h02, 5'h01});
    check("t1_start_early", bus.start, 1'b0);
    tick();
    check("t1_start", bus.start, 1'b1);
    check("t1_we_low", bus.mem_we, 1'b0);
    check("t1_count", bus.line_count, 6'd1);
    tick();
    check("t1_start_pulse", bus.start, 1'b0);
    check("t1_wait_ready", bus.in_ready, 1'b0);
    check("t1_writes", wa.size() - wbase, 1);
    done_pulse("t1_done");

    // Short line: unfilled rows zero.
    send_row(5'h1F, 1'b0);
    send_row(5'h1F, 1'b1);
    check("t2_addr", bus.mem_addr, 6'd0);
    check("t2_wdata", bus.mem_wdata, 25'h00003FF);
    tick();
    check("t2_start", bus.start, 1'b1);
    check("t2_count", bus.line_count, 6'd1);
    tick();

    // Back-pressure across WAIT and the proc_done cycle.
    wbase = wa.size();
    bus.in_valid = 1'b1;
    bus.in_data  = 5'h07;
    bus.in_last  = 1'b1;
`ifdef LINE_LOADER_PARITY_EN
    bus.in_par   = 1'b1;
`endif
    tick();
    tick();
    tick();
    check("t3_wait_ready", bus.in_ready, 1'b0);
    check("t3_no_write", wa.size() - wbase, 0);
    bus.proc_done = 1'b1;
    tick();
    bus.proc_done = 1'b0;
    check("t3_ready_after_done", bus.in_ready, 1'b1);
    check("t3_no_accept_on_done", bus.busy, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("t3_we", bus.mem_we, 1'b1);
    check("t3_wdata", bus.mem_wdata, 25'h0000007);
    tick();
    check("t3_start", bus.start, 1'b1);
    tick();
    check("t3_one_write", wa.size() - wbase, 1);
    done_pulse("t3_done");

    // Overflow: 64 full lines without last.
    wbase = wa.size();
    sbase = start_cnt;
    for (int i = 0; i < 320; i++) send_row(5'(i), 1'b0);
    check("t4_last_we", bus.mem_we, 1'b1);
    check("t4_last_addr", bus.mem_addr, 6'd63);
    tick();
    check("t4_start", bus.start, 1'b1);
    check("t4_overflow", bus.overflow, 1'b1);
    check("t4_ready", bus.in_ready, 1'b0);
    check("t4_write_cnt", wa.size() - wbase, 64);
    errs = 0;
    for (int k = 0; k < 64 && wbase + k < wa.size(); k++) begin
      exp_line = '0;
      for (int j = 0; j < 5; j++) exp_line[j*5 +: 5] = 5'(k*5 + j);
      if (wa[wbase+k] !== 6'(k) || wd[wbase+k] !== exp_line) errs++;
    end
    check("t4_lines", errs, 0);
    wbase = wa.size();
    bus.in_valid = 1'b1;
    bus.in_data  = 5'h0A;
    bus.in_last  = 1'b1;
`ifdef LINE_LOADER_PARITY_EN
    bus.in_par   = 1'b0;
`endif
    for (int n = 0; n < 5; n++) tick();
    check("t4_stall_ready", bus.in_ready, 1'b0);
    check("t4_stall_ovf", bus.overflow, 1'b1);
    check("t4_stall_nowrite", wa.size() - wbase, 0);
    check("t4_one_start", start_cnt - sbase, 1);
    bus.proc_done = 1'b1;
    tick();
    bus.proc_done = 1'b0;
    check("t4_ovf_clr", bus.overflow, 1'b0);
    check("t4_count_clr", bus.line_count, 6'd0);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("t4_new_we", bus.mem_we, 1'b1);
    check("t4_new_addr", bus.mem_addr, 6'd0);
    check("t4_new_wdata", bus.mem_wdata, 25'h000000A);
    tick();
    tick();
    done_pulse("t4_done");

    // Reset mid-line discards the partial line.
    wbase = wa.size();
    sbase = start_cnt;
    send_row(5'h09, 1'b0);
    send_row(5'h08, 1'b0);
    send_row(5'h07, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("t5_no_write", wa.size() - wbase, 0);
    check("t5_no_start", start_cnt - sbase, 0);
    check("t5_busy", bus.busy, 1'b0);
    check("t5_ready", bus.in_ready, 1'b1);
    send_row(5'h11, 1'b0);
    send_row(5'h12, 1'b0);
    send_row(5'h13, 1'b0);
    send_row(5'h14, 1'b0);
    send_row(5'h15, 1'b1);
    check("t5_addr", bus.mem_addr, 6'd0);
    check("t5_wdata", bus.mem_wdata, {5'h15, 5'h14, 5'h13, 5'h12, 5'h11});
    wait_start("t5_start", sbase);
    tick();
    done_pulse("t5_done");

`ifdef LINE_LOADER_PARITY_EN
    sbase = start_cnt;
    check("par_clean", bus.par_err, 1'b0);
    send_row_p(5'h01, 1'b1, 1'b0);
    check("par_err_set", bus.par_err, 1'b1);
    check("par_we", bus.mem_we, 1'b1);
    check("par_wdata", bus.mem_wdata, 25'h0000001);
    wait_start("par_start", sbase);
    tick();
    done_pulse("par_done");
    check("par_err_clr", bus.par_err, 1'b0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire
